grid_planner: RTL

Path planner that drives the `grid` walker. It accepts a target coordinate and emits the sequence of `(direction, steps)` commands that moves the walker from its current position to that target. It keeps a shadow copy of the walker's position, so it never reads `outx`/`outy` back. It sits upstream of `grid`, with `cmd_dir`/`cmd_steps` wired to the walker's `direction`/`steps` inputs.

---
 rtl/grid_pkg.sv | 32 +++
 rtl/grid_axis_step.sv | 21 ++
 rtl/grid_planner.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared definitions for the grid walker and its planner.
// Holds the coordinate and step limits plus the direction and planner state encodings.
package grid_pkg;

  localparam int COORD_W  = 5;
  localparam int GRID_MAX = 15;
  localparam int STEP_MAX = 3;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t GRID_MAX_C = coord_t'(GRID_MAX);
  localparam coord_t STEP_MAX_C = coord_t'(STEP_MAX);

  typedef enum logic [1:0] {
    DIR_XP = 2'd0,
    DIR_XN = 2'd1,
    DIR_YP = 2'd2,
    DIR_YN = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_A = 2'd1,
    ST_MOVE_B = 2'd2,
    ST_DONE   = 2'd3
  } plan_state_e;

  function automatic coord_t clamp_coord(input coord_t c);
    return (c > GRID_MAX_C) ? GRID_MAX_C : c;
  endfunction

endpackage

// File: rtl/grid_axis_step.sv
// One-axis step calculator: direction sign, bounded step count and arrival flag
// for a single coordinate pair. Purely combinational.
module grid_axis_step
  import grid_pkg::*;
(
  input  logic [COORD_W-1:0] i_pos,
  input  logic [COORD_W-1:0] i_tgt,
  output logic               o_neg,
  output logic [1:0]         o_steps,
  output logic               o_at_target
);

  logic [COORD_W-1:0] w_dist;

  // Larger minus smaller keeps the distance unsigned without a sign bit.
  assign o_neg       = (i_tgt < i_pos);
  assign w_dist      = o_neg ? (i_pos - i_tgt) : (i_tgt - i_pos);
  assign o_at_target = (w_dist == '0);
  assign o_steps     = (w_dist > STEP_MAX_C) ? 2'(STEP_MAX) : w_dist[1:0];

endmodule

// File: rtl/grid_planner.sv
// Path planner that converts a target coordinate into (direction, steps) commands
// for the grid walker while tracking a shadow position. Build option
// GRID_PLANNER_YFIRST_EN moves the Y axis before the X axis.
//
// state     | meaning
// ST_IDLE   | waiting for a target, tgt_ready high
// ST_MOVE_A | issuing commands on the first axis
// ST_MOVE_B | issuing commands on the second axis
// ST_DONE   | target reached, done pulses for one cycle
module grid_planner
  import grid_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [COORD_W-1:0] tgt_x,
  input  logic [COORD_W-1:0] tgt_y,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_dir,
  output logic [1:0]         cmd_steps,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               done,
  output logic               clamped
);

  plan_state_e  r_state;
  logic         r_tgt_ready;
  logic         r_cmd_valid;
  dir_e         r_cmd_dir;
  logic [1:0]   r_cmd_steps;
  coord_t       r_pos_x;
  coord_t       r_pos_y;
  coord_t       r_tgt_x;
  coord_t       r_tgt_y;
  logic         r_done;
  logic         r_clamped;

  logic         w_accept;
  logic         w_hs;
  logic         w_hs_x;
  logic         w_hs_y;
  logic         w_over;
  coord_t       w_step_ext;
  coord_t       w_pos_x_nxt;
  coord_t       w_pos_y_nxt;
  coord_t       w_tgt_x_nxt;
  coord_t       w_tgt_y_nxt;

  logic         w_x_neg;
  logic [1:0]   w_x_steps;
  logic         w_x_at;
  logic         w_y_neg;
  logic [1:0]   w_y_steps;
  logic         w_y_at;
  dir_e         w_x_dir;
  dir_e         w_y_dir;

  logic         w_a_at;
  dir_e         w_a_dir;
  logic [1:0]   w_a_steps;
  logic         w_b_at;
  dir_e         w_b_dir;
  logic [1:0]   w_b_steps;

  assign w_accept = tgt_valid & r_tgt_ready;
  assign w_hs     = r_cmd_valid & cmd_ready;
  assign w_hs_x   = w_hs & ((r_cmd_dir == DIR_XP) | (r_cmd_dir == DIR_XN));
  assign w_hs_y   = w_hs & ((r_cmd_dir == DIR_YP) | (r_cmd_dir == DIR_YN));
  assign w_over   = (tgt_x > GRID_MAX_C) | (tgt_y > GRID_MAX_C);

  assign w_step_ext  = {{(COORD_W-2){1'b0}}, r_cmd_steps};
  assign w_pos_x_nxt = !w_hs_x ? r_pos_x :
                       (r_cmd_dir == DIR_XN) ? (r_pos_x - w_step_ext) : (r_pos_x + w_step_ext);
  assign w_pos_y_nxt = !w_hs_y ? r_pos_y :
                       (r_cmd_dir == DIR_YN) ? (r_pos_y - w_step_ext) : (r_pos_y + w_step_ext);
  assign w_tgt_x_nxt = w_accept ? clamp_coord(tgt_x) : r_tgt_x;
  assign w_tgt_y_nxt = w_accept ? clamp_coord(tgt_y) : r_tgt_y;

  // The axis units look at next-cycle position and target so the FSM can
  // register the following command directly off their outputs.
  grid_axis_step u_axis_x (
    .i_pos       (w_pos_x_nxt),
    .i_tgt       (w_tgt_x_nxt),
    .o_neg       (w_x_neg),
    .o_steps     (w_x_steps),
    .o_at_target (w_x_at)
  );

  grid_axis_step u_axis_y (
    .i_pos       (w_pos_y_nxt),
    .i_tgt       (w_tgt_y_nxt),
    .o_neg       (w_y_neg),
    .o_steps     (w_y_steps),
    .o_at_target (w_y_at)
  );

  assign w_x_dir = w_x_neg ? DIR_XN : DIR_XP;
  assign w_y_dir = w_y_neg ? DIR_YN : DIR_YP;

`ifdef GRID_PLANNER_YFIRST_EN
  assign w_a_at    = w_y_at;
  assign w_a_dir   = w_y_dir;
  assign w_a_steps = w_y_steps;
  assign w_b_at    = w_x_at;
  assign w_b_dir   = w_x_dir;
  assign w_b_steps = w_x_steps;
`else
  assign w_a_at    = w_x_at;
  assign w_a_dir   = w_x_dir;
  assign w_a_steps = w_x_steps;
  assign w_b_at    = w_y_at;
  assign w_b_dir   = w_y_dir;
  assign w_b_steps = w_y_steps;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tgt_ready <= 1'b1;
      r_cmd_valid <= 1'b0;
      r_cmd_dir   <= DIR_XP;
      r_cmd_steps <= 2'd0;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_tgt_x     <= '0;
      r_tgt_y     <= '0;
      r_done      <= 1'b0;
      r_clamped   <= 1'b0;
    end else begin
      r_pos_x <= w_pos_x_nxt;
      r_pos_y <= w_pos_y_nxt;
      r_tgt_x <= w_tgt_x_nxt;
      r_tgt_y <= w_tgt_y_nxt;
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_clamped   <= w_over;
            r_tgt_ready <= 1'b0;
            if (!w_a_at) begin
              r_state     <= ST_MOVE_A;
              r_cmd_valid <= 1'b1;
              r_cmd_dir   <= w_a_dir;
              r_cmd_steps <= w_a_steps;
            end else if (!w_b_at) begin
              r_state     <= ST_MOVE_B;
              r_cmd_valid <= 1'b1;
              r_cmd_dir   <= w_b_dir;
              r_cmd_steps <= w_b_steps;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_MOVE_A: begin
          if (w_hs) begin
            if (!w_a_at) begin
              r_cmd_dir   <= w_a_dir;
              r_cmd_steps <= w_a_steps;
            end else if (!w_b_at) begin
              r_state     <= ST_MOVE_B;
              r_cmd_dir   <= w_b_dir;
              r_cmd_steps <= w_b_steps;
            end else begin
              r_state     <= ST_DONE;
              r_cmd_valid <= 1'b0;
              r_cmd_steps <= 2'd0;
              r_done      <= 1'b1;
            end
          end
        end
        ST_MOVE_B: begin
          if (w_hs) begin
            if (!w_b_at) begin
              r_cmd_dir   <= w_b_dir;
              r_cmd_steps <= w_b_steps;
            end else begin
              r_state     <= ST_DONE;
              r_cmd_valid <= 1'b0;
              r_cmd_steps <= 2'd0;
              r_done      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_done      <= 1'b0;
          r_tgt_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_tgt_ready <= 1'b1;
          r_cmd_valid <= 1'b0;
          r_cmd_steps <= 2'd0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign tgt_ready = r_tgt_ready;
  assign cmd_valid = r_cmd_valid;
  assign cmd_dir   = r_cmd_dir;
  assign cmd_steps = r_cmd_steps;
  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign done      = r_done;
  assign clamped   = r_clamped;

endmodule
